// File: rtl/gray_counter.sv
// N-bit up/down counter with a registered, glitch-free Gray copy for cross-domain sampling.
// Adds synchronous load, enable, direction, wrap-or-saturate limits and a one-cycle wrap pulse.
module gray_counter #(
    parameter int          N        = 4,
    parameter bit          SATURATE = 1'b0,
    parameter int unsigned INIT     = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         up_dn,
    input  logic         load,
    input  logic [N-1:0] load_val,
    output logic [N-1:0] bin_out,
    output logic [N-1:0] gray_out,
    output logic         wrap,
    output logic         at_limit
);

    function automatic logic [N-1:0] gray_encode(input logic [N-1:0] b);
        return b ^ (b >> 1);
    endfunction

    localparam logic [N-1:0] INIT_BIN  = INIT[N-1:0];
    localparam logic [N-1:0] INIT_GRAY = gray_encode(INIT_BIN);
    localparam logic [N-1:0] MAX_VAL   = {N{1'b1}};
    localparam logic [N-1:0] ONE       = {{(N-1){1'b0}}, 1'b1};

    logic [N-1:0] bin_q;
    logic [N-1:0] gray_q;
    logic         wrap_q;
    logic [N-1:0] next_bin;
    logic         next_wrap;
    logic         at_max;
    logic         at_min;

    assign at_max = (bin_q == MAX_VAL);
    assign at_min = (bin_q == '0);

    // Limit flag follows the requested direction, regardless of enable.
    assign at_limit = up_dn ? at_max : at_min;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        next_bin  = bin_q;
        next_wrap = 1'b0;
        if (load) begin
            next_bin = load_val;
        end else if (en) begin
            if (up_dn) begin
                if (!at_max) begin
                    next_bin = bin_q + ONE;
                end else if (!SATURATE) begin
                    next_bin  = '0;
                    next_wrap = 1'b1;
                end
            end else begin
                if (!at_min) begin
                    next_bin = bin_q - ONE;
                end else if (!SATURATE) begin
                    next_bin  = MAX_VAL;
                    next_wrap = 1'b1;
                end
            end
        end
    end

    // Gray is encoded from the next binary value and registered on the same edge,
    // so the bus never shows a decode glitch to a foreign clock domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_q  <= INIT_BIN;
            gray_q <= INIT_GRAY;
            wrap_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so all three registers update together from pre-edge values.
            bin_q  <= next_bin;
            gray_q <= gray_encode(next_bin);
            wrap_q <= next_wrap;
        end
    end

    assign bin_out  = bin_q;
    assign gray_out = gray_q;
    assign wrap     = wrap_q;

endmodule

// File: tb/tb_gray_counter.sv
// Directed and scoreboarded checks of gray_counter in wrap, saturate, non-zero INIT and 8-bit configurations.
// Each scenario task drives its own instance and compares outputs 1 time unit after the rising edge.
module tb_gray_counter;

    int total = 0;
    int bad   = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Gray codes of 0..15, hand-derived.
    logic [3:0] gray_tab [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010,
                                  4'b0110, 4'b0111, 4'b0101, 4'b0100,
                                  4'b1100, 4'b1101, 4'b1111, 4'b1110,
                                  4'b1010, 4'b1011, 4'b1001, 4'b1000};

    // Instance a: N=4, INIT=0, wrap mode
    logic       rst_a = 1'b0, en_a = 1'b0, up_a = 1'b1, ld_a = 1'b0;
    logic [3:0] lv_a = '0, bin_a, gray_a;
    logic       wrap_a, lim_a;
    gray_counter #(.N(4), .SATURATE(1'b0), .INIT(0)) u_a (
        .clk(clk), .rst(rst_a), .en(en_a), .up_dn(up_a), .load(ld_a), .load_val(lv_a),
        .bin_out(bin_a), .gray_out(gray_a), .wrap(wrap_a), .at_limit(lim_a));

    // Instance s: N=4, saturate mode
    logic       rst_s = 1'b0, en_s = 1'b0, up_s = 1'b1, ld_s = 1'b0;
    logic [3:0] lv_s = '0, bin_s, gray_s;
    logic       wrap_s, lim_s;
    gray_counter #(.N(4), .SATURATE(1'b1), .INIT(0)) u_s (
        .clk(clk), .rst(rst_s), .en(en_s), .up_dn(up_s), .load(ld_s), .load_val(lv_s),
        .bin_out(bin_s), .gray_out(gray_s), .wrap(wrap_s), .at_limit(lim_s));

    // Instance h: N=4, INIT=5, wrap mode
    logic       rst_h = 1'b0, en_h = 1'b0, up_h = 1'b1, ld_h = 1'b0;
    logic [3:0] lv_h = '0, bin_h, gray_h;
    logic       wrap_h, lim_h;
    gray_counter #(.N(4), .SATURATE(1'b0), .INIT(5)) u_h (
        .clk(clk), .rst(rst_h), .en(en_h), .up_dn(up_h), .load(ld_h), .load_val(lv_h),
        .bin_out(bin_h), .gray_out(gray_h), .wrap(wrap_h), .at_limit(lim_h));

    // Instance r: N=8, INIT=0, wrap mode, random regression
    logic       rst_r = 1'b0, en_r = 1'b0, up_r = 1'b1, ld_r = 1'b0;
    logic [7:0] lv_r = '0, bin_r, gray_r;
    logic       wrap_r, lim_r;
    gray_counter #(.N(8), .SATURATE(1'b0), .INIT(0)) u_r (
        .clk(clk), .rst(rst_r), .en(en_r), .up_dn(up_r), .load(ld_r), .load_val(lv_r),
        .bin_out(bin_r), .gray_out(gray_r), .wrap(wrap_r), .at_limit(lim_r));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_a = 1'b1;
        #2;
        total++;
        if (bin_a !== 4'd0 || gray_a !== 4'b0000 || wrap_a !== 1'b0) begin
            bad++;
            $display("FAIL reset_a: bin=%0d gray=%b wrap=%b, want bin=0 gray=0000 wrap=0", bin_a, gray_a, wrap_a);
        end
        tick();
        rst_a = 1'b0;
        tick();
        total++;
        if (bin_a !== 4'd0 || gray_a !== 4'b0000) begin
            bad++;
            $display("FAIL reset_hold_a: bin=%0d gray=%b, want bin=0 gray=0000", bin_a, gray_a);
        end
    endtask

    task automatic test_up_wrap();
        logic [3:0] exp_bin;
        logic [3:0] prev_gray;
        exp_bin   = 4'd0;
        prev_gray = gray_a;
        en_a = 1'b1;
        up_a = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            exp_bin = exp_bin + 4'd1;
            total++;
            if (bin_a !== exp_bin || gray_a !== gray_tab[exp_bin] || wrap_a !== (exp_bin == 4'd0)) begin
                bad++;
                $display("FAIL up_step%0d: bin=%0d gray=%b wrap=%b, want bin=%0d gray=%b wrap=%b",
                         i, bin_a, gray_a, wrap_a, exp_bin, gray_tab[exp_bin], (exp_bin == 4'd0));
            end
            total++;
            if ($countones(gray_a ^ prev_gray) != 1) begin
                bad++;
                $display("FAIL up_hamming%0d: prev=%b now=%b, want one bit change", i, prev_gray, gray_a);
            end
            prev_gray = gray_a;
        end
        en_a = 1'b0;
    endtask

    task automatic test_down_wrap();
        logic [3:0] exp_bin  [4] = '{4'd1, 4'd0, 4'd15, 4'd14};
        logic [3:0] exp_gray [4] = '{4'b0001, 4'b0000, 4'b1000, 4'b1001};
        logic       exp_wrap [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic       exp_lim  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        ld_a = 1'b1;
        lv_a = 4'd2;
        tick();
        ld_a = 1'b0;
        up_a = 1'b0;
        total++;
        if (bin_a !== 4'd2 || gray_a !== 4'b0011 || wrap_a !== 1'b0 || lim_a !== 1'b0) begin
            bad++;
            $display("FAIL down_load: bin=%0d gray=%b wrap=%b lim=%b, want 2 0011 0 0", bin_a, gray_a, wrap_a, lim_a);
        end
        en_a = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (bin_a !== exp_bin[i] || gray_a !== exp_gray[i] || wrap_a !== exp_wrap[i] || lim_a !== exp_lim[i]) begin
                bad++;
                $display("FAIL down_step%0d: bin=%0d gray=%b wrap=%b lim=%b, want %0d %b %b %b",
                         i, bin_a, gray_a, wrap_a, lim_a, exp_bin[i], exp_gray[i], exp_wrap[i], exp_lim[i]);
            end
        end
        en_a = 1'b0;
    endtask

    task automatic test_load_priority();
        // Run up to 15 and on to 0, so wrap is high when the load arrives.
        ld_a = 1'b1;
        lv_a = 4'd15;
        tick();
        ld_a = 1'b0;
        up_a = 1'b1;
        en_a = 1'b1;
        tick();
        total++;
        if (bin_a !== 4'd0 || wrap_a !== 1'b1) begin
            bad++;
            $display("FAIL prio_setup: bin=%0d wrap=%b, want bin=0 wrap=1", bin_a, wrap_a);
        end
        ld_a = 1'b1;
        lv_a = 4'd10;
        tick();
        total++;
        if (bin_a !== 4'd10 || gray_a !== 4'b1111 || wrap_a !== 1'b0) begin
            bad++;
            $display("FAIL prio_load: bin=%0d gray=%b wrap=%b, want 10 1111 0", bin_a, gray_a, wrap_a);
        end
        ld_a = 1'b0;
        tick();
        total++;
        if (bin_a !== 4'd11 || gray_a !== 4'b1110) begin
            bad++;
            $display("FAIL prio_next: bin=%0d gray=%b, want 11 1110", bin_a, gray_a);
        end
        en_a = 1'b0;
    endtask

    task automatic test_saturate();
        rst_s = 1'b1;
        tick();
        rst_s = 1'b0;
        ld_s  = 1'b1;
        lv_s  = 4'd14;
        up_s  = 1'b1;
        tick();
        ld_s = 1'b0;
        total++;
        if (bin_s !== 4'd14 || gray_s !== 4'b1001 || lim_s !== 1'b0) begin
            bad++;
            $display("FAIL sat_load: bin=%0d gray=%b lim=%b, want 14 1001 0", bin_s, gray_s, lim_s);
        end
        en_s = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (bin_s !== 4'd15 || gray_s !== 4'b1000 || wrap_s !== 1'b0 || lim_s !== 1'b1) begin
                bad++;
                $display("FAIL sat_up%0d: bin=%0d gray=%b wrap=%b lim=%b, want 15 1000 0 1",
                         i, bin_s, gray_s, wrap_s, lim_s);
            end
        end
        up_s = 1'b0;
        tick();
        total++;
        if (bin_s !== 4'd14 || gray_s !== 4'b1001 || wrap_s !== 1'b0) begin
            bad++;
            $display("FAIL sat_turn: bin=%0d gray=%b wrap=%b, want 14 1001 0", bin_s, gray_s, wrap_s);
        end
        // Lower limit: load 1, count down past 0.
        en_s = 1'b0;
        ld_s = 1'b1;
        lv_s = 4'd1;
        tick();
        ld_s = 1'b0;
        en_s = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (bin_s !== 4'd0 || gray_s !== 4'b0000 || wrap_s !== 1'b0 || lim_s !== 1'b1) begin
                bad++;
                $display("FAIL sat_down%0d: bin=%0d gray=%b wrap=%b lim=%b, want 0 0000 0 1",
                         i, bin_s, gray_s, wrap_s, lim_s);
            end
        end
        en_s = 1'b0;
    endtask

    task automatic test_hold_reset();
        rst_h = 1'b1;
        #2;
        total++;
        if (bin_h !== 4'd5 || gray_h !== 4'b0111 || wrap_h !== 1'b0) begin
            bad++;
            $display("FAIL hold_init: bin=%0d gray=%b wrap=%b, want 5 0111 0", bin_h, gray_h, wrap_h);
        end
        tick();
        rst_h = 1'b0;
        en_h  = 1'b1;
        up_h  = 1'b1;
        repeat (4) tick();
        total++;
        if (bin_h !== 4'd9 || gray_h !== 4'b1101) begin
            bad++;
            $display("FAIL hold_count: bin=%0d gray=%b, want 9 1101", bin_h, gray_h);
        end
        en_h = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (bin_h !== 4'd9 || gray_h !== 4'b1101 || wrap_h !== 1'b0) begin
                bad++;
                $display("FAIL hold_cycle%0d: bin=%0d gray=%b wrap=%b, want 9 1101 0", i, bin_h, gray_h, wrap_h);
            end
        end
        #2;
        rst_h = 1'b1;
        #1;
        total++;
        if (bin_h !== 4'd5 || gray_h !== 4'b0111 || wrap_h !== 1'b0) begin
            bad++;
            $display("FAIL async_reset: bin=%0d gray=%b wrap=%b, want 5 0111 0", bin_h, gray_h, wrap_h);
        end
        #1;
        rst_h = 1'b0;
        en_h  = 1'b1;
        tick();
        total++;
        if (bin_h !== 4'd6 || gray_h !== 4'b0101) begin
            bad++;
            $display("FAIL reset_release: bin=%0d gray=%b, want 6 0101", bin_h, gray_h);
        end
        en_h = 1'b0;
    endtask

    task automatic test_random();
        logic [7:0] m_bin;
        logic       m_wrap;
        logic       stepped;
        logic [7:0] prev_gray;
        int         errs;
        errs  = 0;
        rst_r = 1'b1;
        tick();
        rst_r  = 1'b0;
        m_bin  = 8'd0;
        m_wrap = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            en_r = 1'($urandom_range(0, 3) != 0);
            up_r = 1'($urandom_range(0, 1));
            ld_r = 1'($urandom_range(0, 15) == 0);
            lv_r = 8'($urandom_range(0, 255));
            stepped   = en_r && !ld_r;
            prev_gray = gray_r;
            if (ld_r) begin
                m_bin  = lv_r;
                m_wrap = 1'b0;
            end else if (en_r) begin
                m_wrap = up_r ? (m_bin == 8'hFF) : (m_bin == 8'h00);
                m_bin  = up_r ? m_bin + 8'd1 : m_bin - 8'd1;
            end else begin
                m_wrap = 1'b0;
            end
            tick();
            total++;
            if (bin_r !== m_bin || wrap_r !== m_wrap) begin
                bad++;
                errs++;
                if (errs <= 10)
                    $display("FAIL rand_bin%0d: bin=%0d wrap=%b, want %0d %b", i, bin_r, wrap_r, m_bin, m_wrap);
            end
            total++;
            if (gray_r !== (m_bin ^ (m_bin >> 1)) || gray_r !== (bin_r ^ (bin_r >> 1))) begin
                bad++;
                errs++;
                if (errs <= 10)
                    $display("FAIL rand_gray%0d: gray=%b bin=%0d, want %b", i, gray_r, bin_r, m_bin ^ (m_bin >> 1));
            end
            total++;
            if (lim_r !== (up_r ? (m_bin == 8'hFF) : (m_bin == 8'h00))) begin
                bad++;
                errs++;
                if (errs <= 10)
                    $display("FAIL rand_limit%0d: lim=%b bin=%0d up=%b", i, lim_r, bin_r, up_r);
            end
            if (stepped) begin
                total++;
                if ($countones(gray_r ^ prev_gray) != 1) begin
                    bad++;
                    errs++;
                    if (errs <= 10)
                        $display("FAIL rand_hamming%0d: prev=%b now=%b, want one bit change", i, prev_gray, gray_r);
                end
            end
        end
        en_r = 1'b0;
        ld_r = 1'b0;
    endtask

    initial begin
        #1;
        test_reset();
        test_up_wrap();
        test_down_wrap();
        test_load_priority();
        test_saturate();
        test_hold_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
